// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate extender feeding a 2-entry output FIFO.
// Define IMMEXT_ERRCNT_EN to add the saturating err_count port for reserved-mode transfers.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
`ifdef IMMEXT_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t           state_q, state_d;
  logic [OUT_W:0]   head_q, head_d, tail_q, tail_d, ext;
  logic [OUT_W-1:0] sext;
  logic             in_ready_q, in_ready_d, push, pop;
  always_comb begin
    sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    ext  = in_mode[2:1] == 2'b11 ? {1'b1, {OUT_W{1'b0}}} :
           in_mode == 3'b000     ? {1'b0, sext} :
           in_mode == 3'b001     ? {1'b0, {(OUT_W-IN_W){1'b0}}, in_imm} :
           in_mode == 3'b010     ? {1'b0, in_imm, {(OUT_W-IN_W){1'b0}}} :
           in_mode == 3'b011     ? {1'b0, {(OUT_W-8){in_imm[7]}}, in_imm[7:0]} :
           in_mode == 3'b100     ? {1'b0, {(OUT_W-8){1'b0}}, in_imm[7:0]} :
                                   {1'b0, sext[OUT_W-3:0], 2'b00};
  end
  // head always holds the oldest entry so out_data comes straight from a register
  always_comb begin
    push    = in_valid && in_ready_q;
    pop     = state_q != EMPTY && out_ready;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = ext;
      end
      ONE: if (push && pop) head_d = ext;
      else if (push) begin
        state_d = FULL;
        tail_d  = ext;
      end else if (pop) state_d = EMPTY;
      FULL: if (pop) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign out_data  = head_q[OUT_W-1:0];
  assign out_err   = head_q[OUT_W];
`ifdef IMMEXT_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb err_cnt_d = pop && head_q[OUT_W] && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
  assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed stimulus with a scoreboard queue for imm_extend_pipe.
module tb_imm_extend_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [2:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic [32:0] sb[$];
  logic        stall_q = 1'b0;
  logic [32:0] held = '0;
`ifdef IMMEXT_ERRCNT_EN
  logic [7:0]  err_count;
  int          errs_exp = 0;
`endif

  imm_extend_pipe dut (
    .Clk(clk), .Rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
`ifdef IMMEXT_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [2:0] m, input logic [15:0] v);
    logic signed [31:0] s;
    logic [7:0] lo;
    s  = 32'(signed'(v));
    lo = v[7:0];
    case (m)
      3'd0: return {1'b0, s};
      3'd1: return {17'h0, v};
      3'd2: return {1'b0, v, 16'h0};
      3'd3: return {1'b0, 32'(signed'(lo))};
      3'd4: return {25'h0, lo};
      3'd5: return {1'b0, s * 4};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output observed %h expected none", out_data);
      end
      if (sb.size() != 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        checks++;
        assert ({out_err, out_data} === e) else begin
          errors++;
          $error("FAIL scoreboard observed %h expected %h", {out_err, out_data}, e);
        end
        pops++;
`ifdef IMMEXT_ERRCNT_EN
        if (e[32]) errs_exp++;
`endif
      end
    end
    if (stall_q && out_valid) begin
      checks++;
      assert ({out_err, out_data} === held) else begin
        errors++;
        $error("FAIL stall_hold observed %h expected %h", {out_err, out_data}, held);
      end
    end
    stall_q = out_valid && !out_ready;
    held    = {out_err, out_data};
    if (in_valid && in_ready) sb.push_back(model(in_mode, in_imm));
  end

  initial begin
    logic [31:0] mode_exp [5];
    int p0;
    mode_exp = '{32'h000080F4, 32'h80F40000, 32'hFFFFFFF4, 32'h000000F4, 32'hFFFE03D0};
    #2;
    chk("rst_out_valid", 33'(out_valid), 33'(0));
    chk("rst_in_ready", 33'(in_ready), 33'(0));
    chk("rst_out", {out_err, out_data}, 33'h0);
    step();
    step();
    rst_n = 1'b1;
    chk("in_ready_before_edge", 33'(in_ready), 33'(0));
    step();
    chk("in_ready_after_rst", 33'(in_ready), 33'(1));
    // sign extend with one-cycle latency
    in_valid = 1'b1; in_mode = 3'd0; in_imm = 16'h8001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("m0_valid", 33'(out_valid), 33'(1));
    chk("m0_data", {out_err, out_data}, 33'h0FFFF8001);
    step();
    chk("m0_drained", 33'(out_valid), 33'(0));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mode = 3'(i + 1); in_imm = 16'h80F4;
      step();
      in_valid = 1'b0;
      chk($sformatf("mode%0d", i + 1), {out_err, out_data}, {1'b0, mode_exp[i]});
      step();
    end
    in_valid = 1'b1; in_mode = 3'd6; in_imm = 16'hFFFF;
    step();
    in_valid = 1'b0;
    chk("mode6", {out_err, out_data}, 33'h100000000);
    step();
    // backpressure: third word must be refused
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1; in_imm = 16'h1111;
    step();
    in_imm = 16'h2222;
    step();
    chk("full_in_ready", 33'(in_ready), 33'(0));
    in_imm = 16'h3333;
    step();
    step();
    chk("full_ignore", {out_err, out_data}, 33'h000001111);
    chk("full_in_ready2", 33'(in_ready), 33'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("drain_word2", {out_err, out_data}, 33'h000002222);
    chk("drain_in_ready", 33'(in_ready), 33'(1));
    step();
    chk("drain_empty", 33'(out_valid), 33'(0));
    // streaming at one word per cycle
    p0 = pops;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_mode = 3'($urandom_range(0, 5));
      in_imm  = 16'($urandom);
      step();
      chk("stream_valid", 33'(out_valid), 33'(1));
      chk("stream_ready", 33'(in_ready), 33'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 33'(pops - p0), 33'(10));
    // reserved mode repeated past counter saturation
    in_valid = 1'b1; in_mode = 3'd7; in_imm = 16'h5A5A;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    step();
    step();
`ifdef IMMEXT_ERRCNT_EN
    chk("err_count_sat", 33'(err_count), 33'(errs_exp > 255 ? 255 : errs_exp));
`endif
    // reset while full discards both entries
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1; in_imm = 16'hAAAA;
    step();
    in_imm = 16'hBBBB;
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", 33'(in_ready), 33'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 33'(out_valid), 33'(0));
    chk("mid_rst_data", {out_err, out_data}, 33'h0);
    chk("mid_rst_ready", 33'(in_ready), 33'(0));
    sb.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_ready", 33'(in_ready), 33'(1));
    chk("post_rst_no_stale", 33'(out_valid), 33'(0));
    in_valid = 1'b1; in_mode = 3'd4; in_imm = 16'h12C3;
    step();
    in_valid = 1'b0;
    chk("post_rst_word", {out_err, out_data}, 33'h0000000C3);
    step();
    step();
    chk("sb_empty", 33'(sb.size()), 33'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning immediate input width; legal range 8 to OUT_W-2.
REQ-002 The block SHALL have parameter OUT_W, default 32, meaning extended output width.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream word is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle; driven from a register.
REQ-007 The block SHALL have port in_imm, input, IN_W bits, the raw immediate.
REQ-008 The block SHALL have port in_mode, input, 3 bits, the extension mode.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts out_data.
REQ-011 The block SHALL have port out_data, output, OUT_W bits, the extended word.
REQ-012 The block SHALL have port out_err, output, 1 bit, set with out_data when the source mode was reserved.
REQ-013 With IMMEXT_ERRCNT_EN defined, the block SHALL have port err_count, output, 8 bits, the count of reserved-mode transfers.

Function
REQ-014 Mode 000 SHALL sign-extend: out = in_imm with bits OUT_W-1:IN_W copied from in_imm[IN_W-1].
REQ-015 Mode 001 SHALL zero-extend in_imm.
REQ-016 Mode 010 SHALL place in_imm at out[OUT_W-1:OUT_W-IN_W] and zero all lower bits.
REQ-017 Mode 011 SHALL sign-extend in_imm[7:0]; mode 100 SHALL zero-extend in_imm[7:0].
REQ-018 Mode 101 SHALL sign-extend in_imm and then shift it left 2, discarding the top 2 bits.
REQ-019 Modes 110 and 111 SHALL produce out_data = 0 with out_err = 1; all other modes SHALL give out_err = 0.
REQ-020 An input transfer SHALL occur when in_valid && in_ready, and an output transfer when out_valid && out_ready.
REQ-021 The block SHALL buffer results in a 2-entry FIFO with states EMPTY, ONE, and FULL, in order.
REQ-022 The result of an input transfer in cycle N SHALL be presented on out_data no earlier than cycle N+1.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL be updated one cycle after the occupancy change.
REQ-024 A simultaneous input and output transfer in ONE SHALL keep state ONE and SHALL sustain one word per cycle.
REQ-025 An output transfer from FULL SHALL move to ONE; the older entry SHALL always leave first.
REQ-026 out_data and out_err SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-027 in_valid in FULL SHALL be ignored, with no state change.

Reset
REQ-028 Rst_n = 0 SHALL immediately force state EMPTY, out_valid = 0, in_ready = 0, out_data = 0, out_err = 0 and err_count = 0, without waiting for Clk.
REQ-029 in_ready SHALL rise on the first Clk edge after Rst_n deasserts.
REQ-030 Any entry buffered when Rst_n asserts mid-operation SHALL be discarded.

Configuration
REQ-031 With macro IMMEXT_ERRCNT_EN defined, err_count SHALL increment on each output transfer with out_err = 1 and SHALL saturate at 255.
REQ-032 Without IMMEXT_ERRCNT_EN, port err_count and the counter logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Defaults, mode 000, in_imm 16'h8001, out_ready = 1 -> out_data 32'hFFFF8001, out_err 0, one cycle later.
REQ-034 Modes 001/010/011/100/101 with in_imm 16'h80F4 -> 32'h000080F4 / 32'h80F40000 / 32'hFFFFFFF4 / 32'h000000F4 / 32'hFFFE03D0.
REQ-035 Hold out_ready = 0 and send 3 words -> in_ready drops after 2 words; word 3 is ignored; releasing out_ready drains words 1 and 2 in order.
REQ-036 Continuous in_valid = 1 and out_ready = 1 for 10 words -> 10 outputs in 10 consecutive cycles, state ONE throughout.
REQ-037 Mode 111 sent 300 times with IMMEXT_ERRCNT_EN defined -> every output is 0 with out_err 1; err_count stops at 8'hFF.
REQ-038 Pulse Rst_n low mid-stream while FULL -> out_valid 0 immediately, no stale word after release, in_ready 1 after the first edge.
